// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Sequences the PC register and the instruction-memory port of the
// single-cycle RV32I core: request at pc_in, wait for the response, hold the
// word for decode, then pulse pc_load with sequential/branch select.
// ECALL/EBREAK retirement and response timeouts stop the controller until arst.
//
// Ports
//   clk, arst                      clock (rising edge), async active-low reset
//   en                             run enable (sampled in IDLE and at HOLD exit)
//   pc_in                          current PC from the PC register
//   imem_req_valid/addr/ready      fetch request channel
//   imem_rsp_valid/data            fetch response (valid only)
//   instr_valid/instr/instr_ready  held instruction to decode
//   branch_taken                   branch resolution, used with instr handshake
//   pc_load, pc_src                PC update strobe, 0 = PC+4, 1 = PC+ImmExt
//   halt, fault                    sticky stop flags
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | stopped, waiting for en
// REQ   | request valid at pc_in until the memory accepts it
// WAIT  | request accepted, counting cycles until the response
// HOLD  | instruction held for decode until instr_ready
// HALT  | ECALL/EBREAK retired, stopped until reset
// FAULT | response timeout, stopped until reset
module fetch_ctrl #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        en,
    input  logic [31:0] pc_in,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic        branch_taken,
    output logic        pc_load,
    output logic        pc_src,
    output logic        halt,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT,
        S_FAULT
    } state_t;

    // The counter holds the number of WAIT cycles already spent without a
    // response, so the fault fires at the end of WAIT cycle TIMEOUT_MAX.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          instr_q, instr_d;
    logic                 is_system;

    // ECALL / EBREAK: SYSTEM opcode, funct3 0, rd = rs1 = 0, imm 0 or 1.
    // Bit 20 (imm[0]) is the only don't-care bit.
    assign is_system = ({instr_q[31:21], instr_q[19:0]} == {11'd0, 20'h00073});

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        instr_d        = instr_q;
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        instr_valid    = 1'b0;
        instr          = '0;
        pc_load        = 1'b0;
        pc_src         = 1'b0;
        halt           = 1'b0;
        fault          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_REQ;
            end
            S_REQ: begin
                // en is not looked at here: a raised request is never withdrawn.
                imem_req_valid = 1'b1;
                imem_req_addr  = pc_in;
                if (imem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                instr       = instr_q;
                if (instr_ready) begin
                    if (is_system) begin
                        // PC is left pointing at the system instruction.
                        state_d = S_HALT;
                    end else begin
                        pc_load = 1'b1;
                        pc_src  = branch_taken;
                        state_d = en ? S_REQ : S_IDLE;
                    end
                end
            end
            S_HALT: begin
                halt = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk;
    logic        arst;
    logic        en;
    logic [31:0] pc_in;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        branch_taken;
    logic        pc_load;
    logic        pc_src;
    logic        halt;
    logic        fault;

    int total;
    int bad;

    logic [31:0] pc_reg;
    logic [31:0] pc_reset_val;
    logic [31:0] mem_ovr [int unsigned];

    fetch_ctrl #(
        .TIMEOUT_W  (8),
        .TIMEOUT_MAX(4)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .en            (en),
        .pc_in         (pc_in),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .pc_load       (pc_load),
        .pc_src        (pc_src),
        .halt          (halt),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bimm(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    // Instruction memory contents: hashed non-SYSTEM words unless overridden.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = (a * 32'h9E37_79B1) ^ 32'h7F4A_7C15;
        return {h[31:7], (h[8] ? 7'b1100011 : 7'b0010011)};
    endfunction

    // External PC register, fed from pc_load/pc_src and the decoded ImmExt.
    always @(posedge clk or negedge arst) begin
        if (!arst)        pc_reg <= pc_reset_val;
        else if (pc_load) pc_reg <= pc_src ? pc_reg + bimm(instr) : pc_reg + 32'd4;
    end
    assign pc_in = pc_reg;

    task automatic step(input bit rdy, input bit rsp, input logic [31:0] d,
                        input bit irdy, input bit br);
        @(negedge clk);
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = d;
        instr_ready    = irdy;
        branch_taken   = br;
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        @(negedge clk);
        arst           = 1'b0;
        en             = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        branch_taken   = 1'b0;
        pc_reset_val   = pc0;
        repeat (2) @(negedge clk);
        arst = 1'b1;
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    // Transaction-level model: the bench tracks whether a fetch is outstanding
    // or an instruction is held, and the architectural PC it expects next.
    task automatic run_stream(input int n, input int rdy_pct, input int max_delay,
                              input int irdy_pct, input int br_pct, input bit noise,
                              input bit check_spacing);
        bit          pending = 0;
        bit          have = 0;
        int          widx = 0;
        int          delay = 1;
        int          cyc = 0;
        int          last_acc = -1;
        int          retired = 0;
        logic [31:0] exp_pc = pc_reset_val;
        logic [31:0] held = '0;
        bit rdy, irdy, br, rsp, exp_req;
        logic [31:0] d;
        while (retired < n && cyc < 40 * n + 100) begin
            rdy  = pct(rdy_pct);
            irdy = pct(irdy_pct);
            br   = pct(br_pct);
            rsp  = 0;
            d    = $urandom;
            if (pending && widx == delay) begin
                rsp = 1;
                d   = word_at(exp_pc);
            end else if (noise && have) begin
                rsp = $urandom_range(0, 1);
            end
            step(rdy, rsp, d, irdy, br);
            exp_req = !pending && !have;
            total++;
            if (imem_req_valid !== exp_req) begin
                bad++;
                $display("FAIL stream_req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, exp_req);
            end
            if (exp_req) begin
                total++;
                if (imem_req_addr !== exp_pc) begin
                    bad++;
                    $display("FAIL stream_req_addr got=%h want=%h", imem_req_addr, exp_pc);
                end
            end
            total++;
            if (instr_valid !== have) begin
                bad++;
                $display("FAIL stream_instr_valid cyc=%0d got=%b want=%b", cyc, instr_valid, have);
            end
            total++;
            if (halt !== 1'b0 || fault !== 1'b0) begin
                bad++;
                $display("FAIL stream_sticky got halt=%b fault=%b want 0 0", halt, fault);
            end
            if (have && irdy) begin
                total++;
                if (instr !== held || pc_load !== 1'b1 || pc_src !== br) begin
                    bad++;
                    $display("FAIL stream_retire got instr=%h load=%b src=%b want instr=%h load=1 src=%b",
                             instr, pc_load, pc_src, held, br);
                end
                exp_pc  = br ? exp_pc + bimm(held) : exp_pc + 32'd4;
                have    = 0;
                retired++;
            end else begin
                total++;
                if (pc_load !== 1'b0 || pc_src !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_pc_idle got load=%b src=%b want 0 0", pc_load, pc_src);
                end
                if (have) begin
                    total++;
                    if (instr !== held) begin
                        bad++;
                        $display("FAIL stream_instr_hold got=%h want=%h", instr, held);
                    end
                end
            end
            if (exp_req && rdy) begin
                if (check_spacing && last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != 3) begin
                        bad++;
                        $display("FAIL stream_spacing got=%0d want=3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                pending  = 1;
                widx     = 1;
                delay    = $urandom_range(1, max_delay);
            end else if (pending) begin
                if (rsp) begin
                    pending = 0;
                    have    = 1;
                    held    = word_at(exp_pc);
                end else begin
                    widx++;
                end
            end
            cyc++;
        end
        total++;
        if (retired != n) begin
            bad++;
            $display("FAIL stream_budget got retired=%0d want=%0d", retired, n);
        end
    endtask

    task automatic test_reset();
        logic [69:0] o;
        do_reset(32'h1234_5678);
        step(1, 1, 32'hFFFF_FFFF, 1, 1);
        o = {imem_req_valid, imem_req_addr, instr_valid, instr, pc_load, pc_src, halt, fault};
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL reset_idle_outputs got=%h want=0", o);
        end
        step(1, 1, 32'hFFFF_FFFF, 1, 1);
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req_without_en got=%b want=0", imem_req_valid);
        end
    endtask

    task automatic test_sequential();
        do_reset(32'h0);
        en = 1'b1;
        run_stream(6, 100, 1, 100, 0, 0, 1);
    endtask

    task automatic test_branch();
        mem_ovr[32'h10] = 32'h0000_0463;
        do_reset(32'h10);
        en = 1'b1;
        step(1, 0, 0, 0, 0);
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            bad++;
            $display("FAIL branch_req got v=%b a=%h want v=1 a=00000010", imem_req_valid, imem_req_addr);
        end
        step(1, 1, 32'h0000_0463, 0, 0);
        step(1, 0, 0, 1, 1);
        total++;
        if (instr !== 32'h0000_0463 || pc_load !== 1'b1 || pc_src !== 1'b1) begin
            bad++;
            $display("FAIL branch_handshake got instr=%h load=%b src=%b want 00000463 1 1", instr, pc_load, pc_src);
        end
        step(1, 0, 0, 0, 0);
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h18) begin
            bad++;
            $display("FAIL branch_target got v=%b a=%h want v=1 a=00000018", imem_req_valid, imem_req_addr);
        end
        mem_ovr.delete(32'h10);
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        w = word_at(32'h20);
        do_reset(32'h20);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            step(0, 0, 0, 0, 0);
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20 || pc_load !== 1'b0) begin
                bad++;
                $display("FAIL bp_req_stall i=%0d got v=%b a=%h load=%b want 1 00000020 0",
                         i, imem_req_valid, imem_req_addr, pc_load);
            end
        end
        en = 1'b1;
        step(1, 0, 0, 0, 0);
        step(0, 1, w, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1);
            total++;
            if (instr_valid !== 1'b1 || instr !== w || pc_load !== 1'b0 || imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_stall i=%0d got v=%b instr=%h load=%b req=%b want 1 %h 0 0",
                         i, instr_valid, instr, pc_load, imem_req_valid, w);
            end
        end
        step(0, 0, 0, 1, 0);
        total++;
        if (pc_load !== 1'b1 || pc_src !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake got load=%b src=%b want 1 0", pc_load, pc_src);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h24) begin
            bad++;
            $display("FAIL bp_next_req got v=%b a=%h want 1 00000024", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_halt();
        logic [31:0] words [3] = '{32'h0000_0073, 32'h0010_0073, 32'h0020_0073};
        bit          stops [3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            mem_ovr[32'h40] = words[k];
            do_reset(32'h40);
            en = 1'b1;
            step(1, 0, 0, 0, 0);
            step(1, 1, words[k], 0, 0);
            step(1, 0, 0, 1, 0);
            total++;
            if (pc_load !== !stops[k]) begin
                bad++;
                $display("FAIL halt_pc_load word=%h got=%b want=%b", words[k], pc_load, !stops[k]);
            end
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 0, 1, 0);
                total++;
                if (halt !== stops[k] || (stops[k] && (imem_req_valid !== 1'b0 || pc_load !== 1'b0
                                                      || instr_valid !== 1'b0))) begin
                    bad++;
                    $display("FAIL halt_sticky word=%h i=%0d got halt=%b req=%b load=%b want halt=%b",
                             words[k], i, halt, imem_req_valid, pc_load, stops[k]);
                end
            end
        end
        mem_ovr.delete(32'h40);
        do_reset(32'h0);
        step(0, 0, 0, 0, 0);
        total++;
        if (halt !== 1'b0) begin
            bad++;
            $display("FAIL halt_cleared_by_reset got=%b want=0", halt);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        do_reset(32'h50);
        en = 1'b1;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            total++;
            if (fault !== 1'b0 || imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL timeout_wait i=%0d got fault=%b req=%b want 0 0", i, fault, imem_req_valid);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h13, 1, 0);
            total++;
            if (fault !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL timeout_fault i=%0d got fault=%b req=%b iv=%b want 1 0 0",
                         i, fault, imem_req_valid, instr_valid);
            end
        end
        w = word_at(32'h50);
        do_reset(32'h50);
        en = 1'b1;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(1, 1, w, 0, 0);
        step(1, 0, 0, 0, 0);
        total++;
        if (fault !== 1'b0 || instr_valid !== 1'b1 || instr !== w) begin
            bad++;
            $display("FAIL timeout_last_cycle_rsp got fault=%b iv=%b instr=%h want 0 1 %h",
                     fault, instr_valid, instr, w);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [69:0] o;
        do_reset(32'h60);
        en = 1'b1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #2 arst = 1'b0;
        #1;
        o = {imem_req_valid, imem_req_addr, instr_valid, instr, pc_load, pc_src, halt, fault};
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL async_reset_outputs got=%h want=0", o);
        end
        @(negedge clk);
        arst = 1'b1;
        step(1, 0, 0, 0, 0);
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h60) begin
            bad++;
            $display("FAIL reset_restart got v=%b a=%h want 1 00000060", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_en_drop();
        logic [31:0] w;
        int loads = 0;
        w = word_at(32'h70);
        do_reset(32'h70);
        en = 1'b1;
        step(1, 0, 0, 0, 0);
        en = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 1, w, 0, 0);
        step(1, 0, 0, 1, 0);
        total++;
        if (instr_valid !== 1'b1 || instr !== w || pc_load !== 1'b1) begin
            bad++;
            $display("FAIL en_drop_deliver got iv=%b instr=%h load=%b want 1 %h 1", instr_valid, instr, pc_load, w);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h13, 1, 0);
            if (pc_load) loads++;
            total++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL en_drop_idle i=%0d got req=%b iv=%b want 0 0", i, imem_req_valid, instr_valid);
            end
        end
        total++;
        if (loads != 0) begin
            bad++;
            $display("FAIL en_drop_single_load got extra=%0d want=0", loads);
        end
    endtask

    task automatic test_random();
        do_reset(32'h100);
        en = 1'b1;
        run_stream(60, 60, 4, 55, 30, 1, 0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        arst         = 1'b0;
        en           = 1'b0;
        pc_reset_val = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        branch_taken   = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_backpressure();
        test_halt();
        test_timeout();
        test_reset_mid_wait();
        test_en_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
